// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving NUM_PORTS requesters one-at-a-time access to a word memory.
// Define MEM_ARBITER_BOUNDS_CHECK_EN to flag out-of-range addresses instead of wrapping them.
module mem_arbiter #(
   parameter int unsigned NUM_PORTS   = 2,
   parameter int unsigned NUM_BYTES   = 64,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_PORTS-1:0]      req_valid,
   input  logic [NUM_PORTS-1:0]      req_write,
   input  logic [32*NUM_PORTS-1:0]   req_addr,
   input  logic [32*NUM_PORTS-1:0]   req_wdata,
   output logic [NUM_PORTS-1:0]      req_ready,
   output logic [NUM_PORTS-1:0]      rsp_valid,
   output logic [32*NUM_PORTS-1:0]   rsp_rdata,
   output logic [NUM_PORTS-1:0]      rsp_err
);

   localparam int unsigned Words    = NUM_BYTES / 4;
   localparam int unsigned PW       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int unsigned AW       = (Words > 1) ? $clog2(Words) : 1;
   localparam logic [3:0]  WaitLoad = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   state_e                   state_q;
   logic [PW-1:0]            last_grant_q;
   logic [3:0]               cnt_q;
   logic                     wr_q;
   logic [31:0]              addr_q;
   logic [31:0]              wdata_q;
   logic [NUM_PORTS-1:0]     rsp_valid_q;
   logic [NUM_PORTS-1:0]     rsp_err_q;
   logic [32*NUM_PORTS-1:0]  rsp_rdata_q;
   logic [31:0]              mem [Words];

   logic                     gnt_found;
   logic [PW-1:0]            gnt_idx;
   logic [PW-1:0]            cand;
   logic                     sel_write;
   logic [31:0]              sel_addr;
   logic [31:0]              sel_wdata;
   logic [PW-1:0]            nxt_gnt;
   logic                     nxt_write;
   logic [31:0]              nxt_addr;
   logic                     nxt_err;
   logic [31:0]              nxt_rdata;

   function automatic logic [AW-1:0] word_index(input logic [31:0] a);
      return AW'((a >> 2) % 32'(Words));
   endfunction

   // Search upward from the channel after the last winner.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int i = 1; i <= int'(NUM_PORTS); i++) begin
         cand = PW'((int'(last_grant_q) + i) % int'(NUM_PORTS));
         if (!gnt_found && req_valid[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

   assign sel_write = req_write[gnt_idx];
   assign sel_addr  = req_addr[{gnt_idx, 5'd0} +: 32];
   assign sel_wdata = req_wdata[{gnt_idx, 5'd0} +: 32];

   // Transaction that will enter RESP next: the live winner from IDLE, else the captured one.
   assign nxt_gnt   = (state_q == StIdle) ? gnt_idx : last_grant_q;
   assign nxt_write = (state_q == StIdle) ? sel_write : wr_q;
   assign nxt_addr  = (state_q == StIdle) ? sel_addr : addr_q;

`ifdef MEM_ARBITER_BOUNDS_CHECK_EN
   assign nxt_err = (nxt_addr >= 32'(NUM_BYTES));
`else
   assign nxt_err = 1'b0;
`endif

   assign nxt_rdata = (nxt_write || nxt_err) ? 32'h0 : mem[word_index(nxt_addr)];

   // Outputs are forced low while reset is held so an aborted RESP never shows a response.
   always_comb begin
      req_ready = '0;
      if (!reset && state_q == StIdle && gnt_found) begin
         req_ready[gnt_idx] = 1'b1;
      end
   end

   assign rsp_valid = reset ? '0 : rsp_valid_q;
   assign rsp_err   = reset ? '0 : rsp_err_q;
   assign rsp_rdata = reset ? '0 : rsp_rdata_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         last_grant_q <= PW'(NUM_PORTS - 1);
         cnt_q        <= 4'd0;
         wr_q         <= 1'b0;
         addr_q       <= 32'h0;
         wdata_q      <= 32'h0;
         rsp_valid_q  <= '0;
         rsp_err_q    <= '0;
         rsp_rdata_q  <= '0;
      end else begin
         rsp_valid_q <= '0;
         rsp_err_q   <= '0;
         rsp_rdata_q <= '0;
         unique case (state_q)
            StIdle: begin
               if (gnt_found) begin
                  last_grant_q <= gnt_idx;
                  wr_q         <= sel_write;
                  addr_q       <= sel_addr;
                  wdata_q      <= sel_wdata;
                  if (WAIT_STATES > 0) begin
                     state_q <= StWait;
                     cnt_q   <= WaitLoad;
                  end else begin
                     state_q                           <= StResp;
                     rsp_valid_q[nxt_gnt]              <= 1'b1;
                     rsp_err_q[nxt_gnt]                <= nxt_err;
                     rsp_rdata_q[{nxt_gnt, 5'd0} +: 32] <= nxt_rdata;
                  end
               end
            end
            StWait: begin
               if (cnt_q == 4'd0) begin
                  state_q                           <= StResp;
                  rsp_valid_q[nxt_gnt]              <= 1'b1;
                  rsp_err_q[nxt_gnt]                <= nxt_err;
                  rsp_rdata_q[{nxt_gnt, 5'd0} +: 32] <= nxt_rdata;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            StResp: state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

   // Write commits on the edge that leaves RESP, unless reset is sampled on that edge.
   always_ff @(posedge clk) begin
      if (!reset && state_q == StResp && wr_q && !nxt_err) begin
         mem[word_index(addr_q)] <= wdata_q;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: 2-port zero-wait, 4-port round-robin and 2-port three-wait-state instances.
module tb_mem_arbiter;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   logic [1:0]   a_valid = '0, a_write = '0, a_ready, a_rvalid, a_err;
   logic [63:0]  a_addr = '0, a_wdata = '0, a_rdata;
   logic [3:0]   b_valid = '0, b_write = '0, b_ready, b_rvalid, b_err;
   logic [127:0] b_addr = '0, b_wdata = '0, b_rdata;
   logic [1:0]   c_valid = '0, c_write = '0, c_ready, c_rvalid, c_err;
   logic [63:0]  c_addr = '0, c_wdata = '0, c_rdata;

   mem_arbiter #(.NUM_PORTS(2), .NUM_BYTES(64), .WAIT_STATES(0)) dut_a (
      .clk(clk), .reset(reset), .req_valid(a_valid), .req_write(a_write), .req_addr(a_addr),
      .req_wdata(a_wdata), .req_ready(a_ready), .rsp_valid(a_rvalid), .rsp_rdata(a_rdata),
      .rsp_err(a_err));

   mem_arbiter #(.NUM_PORTS(4), .NUM_BYTES(64), .WAIT_STATES(0)) dut_b (
      .clk(clk), .reset(reset), .req_valid(b_valid), .req_write(b_write), .req_addr(b_addr),
      .req_wdata(b_wdata), .req_ready(b_ready), .rsp_valid(b_rvalid), .rsp_rdata(b_rdata),
      .rsp_err(b_err));

   mem_arbiter #(.NUM_PORTS(2), .NUM_BYTES(64), .WAIT_STATES(3)) dut_c (
      .clk(clk), .reset(reset), .req_valid(c_valid), .req_write(c_write), .req_addr(c_addr),
      .req_wdata(c_wdata), .req_ready(c_ready), .rsp_valid(c_rvalid), .rsp_rdata(c_rdata),
      .rsp_err(c_err));

   // One transaction on dut_a; returns the response once it appears (bounded waits).
   task automatic a_xfer(input logic p, input logic w, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] rd, output logic er);
      bit got = 0;
      rd = 32'h0;
      er = 1'b0;
      @(negedge clk);
      a_valid = '0;
      a_valid[p] = 1'b1;
      a_write[p] = w;
      a_addr[{p, 5'd0} +: 32] = addr;
      a_wdata[{p, 5'd0} +: 32] = wd;
      for (int n = 0; n < 8 && !got; n++) begin
         #1;
         if (a_ready[p]) got = 1;
         else @(negedge clk);
      end
      if (!got) begin
         total++; bad++;
         $display("FAIL xfer_accept: no req_ready within 8 cycles, required ready");
      end
      @(negedge clk);
      a_valid = '0;
      got = 0;
      for (int n = 0; n < 8 && !got; n++) begin
         #1;
         if (a_rvalid[p]) begin
            got = 1;
            rd = a_rdata[{p, 5'd0} +: 32];
            er = a_err[p];
         end else @(negedge clk);
      end
      if (!got) begin
         total++; bad++;
         $display("FAIL xfer_rsp: no rsp_valid within 8 cycles, required response");
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      a_valid = 2'b11;
      repeat (2) @(negedge clk);
      #1;
      total++; if (a_ready !== 2'b00) begin bad++; $display("FAIL rst_ready: got %b want 00", a_ready); end
      total++; if (a_rvalid !== 2'b00) begin bad++; $display("FAIL rst_rvalid: got %b want 00", a_rvalid); end
      a_valid = '0;
      @(negedge clk);
      reset = 1'b0;
      #1;
      total++; if (a_rdata !== 64'h0 || a_err !== 2'b00) begin
         bad++; $display("FAIL rst_rsp: rdata %h err %b want 0", a_rdata, a_err);
      end
      total++; if (b_ready !== 4'h0 || c_ready !== 2'b00) begin
         bad++; $display("FAIL rst_idle: b %b c %b want 0", b_ready, c_ready);
      end
      @(negedge clk);
      a_valid = 2'b11;
      a_write = 2'b00;
      #1;
      total++; if (a_ready !== 2'b01) begin bad++; $display("FAIL first_grant: got %b want 01", a_ready); end
      @(negedge clk);
      a_valid = '0;
      @(negedge clk);
   endtask

   task automatic test_write_read();
      @(negedge clk);
      a_valid = 2'b10; a_write = 2'b10;
      a_addr[63:32] = 32'h08; a_wdata[63:32] = 32'hDEADBEEF;
      #1;
      total++; if (a_ready !== 2'b10) begin bad++; $display("FAIL wr_accept: got %b want 10", a_ready); end
      @(negedge clk);
      a_valid = '0;
      #1;
      total++; if (a_rvalid !== 2'b10 || a_rdata !== 64'h0) begin
         bad++; $display("FAIL wr_rsp: rvalid %b rdata %h want 10/0", a_rvalid, a_rdata);
      end
      total++; if (a_ready !== 2'b00) begin bad++; $display("FAIL wr_rsp_ready: got %b want 00", a_ready); end
      @(negedge clk);
      a_valid = 2'b01; a_write = 2'b00; a_addr[31:0] = 32'h08;
      #1;
      total++; if (a_ready !== 2'b01) begin bad++; $display("FAIL rd_accept: got %b want 01", a_ready); end
      @(negedge clk);
      a_valid = '0;
      #1;
      total++; if (a_rvalid !== 2'b01 || a_rdata !== 64'h0000_0000_DEAD_BEEF) begin
         bad++; $display("FAIL rd_data: rvalid %b rdata %h want 01/deadbeef", a_rvalid, a_rdata);
      end
      @(negedge clk);
   endtask

   task automatic test_round_robin();
      logic [3:0] er [10];
      logic [3:0] ev [10];
      er = '{4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1, 4'h0};
      ev = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1};
      @(negedge clk);
      b_valid = 4'hF; b_write = 4'h0;
      b_addr = {32'h0C, 32'h08, 32'h04, 32'h00};
      for (int i = 0; i < 10; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         total++; if (b_ready !== er[i]) begin
            bad++; $display("FAIL rr_ready[%0d]: got %b want %b", i, b_ready, er[i]);
         end
         total++; if (b_rvalid !== ev[i]) begin
            bad++; $display("FAIL rr_rvalid[%0d]: got %b want %b", i, b_rvalid, ev[i]);
         end
      end
      @(negedge clk);
      b_valid = '0;
   endtask

   task automatic test_wait_states();
      @(negedge clk);
      c_valid = 2'b10; c_write = 2'b10;
      c_addr[63:32] = 32'h0C; c_wdata[63:32] = 32'h0000CAFE;
      #1;
      total++; if (c_ready !== 2'b10) begin bad++; $display("FAIL ws_accept: got %b want 10", c_ready); end
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         if (k == 1) c_valid = '0;
         #1;
         total++; if (c_ready !== 2'b00) begin
            bad++; $display("FAIL ws_ready[T+%0d]: got %b want 00", k, c_ready);
         end
         total++; if (c_rvalid !== ((k == 4) ? 2'b10 : 2'b00)) begin
            bad++; $display("FAIL ws_rvalid[T+%0d]: got %b", k, c_rvalid);
         end
      end
      @(negedge clk);
      c_valid = 2'b01; c_write = 2'b00; c_addr[31:0] = 32'h0C;
      #1;
      total++; if (c_ready !== 2'b01) begin bad++; $display("FAIL ws_next_accept: got %b want 01", c_ready); end
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         if (k == 1) c_valid = '0;
         #1;
         total++; if (c_rvalid !== ((k == 4) ? 2'b01 : 2'b00)) begin
            bad++; $display("FAIL ws_rd_rvalid[T+%0d]: got %b", k, c_rvalid);
         end
      end
      total++; if (c_rdata !== 64'h0000_0000_0000_CAFE) begin
         bad++; $display("FAIL ws_rdata: got %h want cafe", c_rdata);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd;
      logic er;
      a_xfer(1'b0, 1'b1, 32'h04, 32'h11111111, rd, er);
      @(negedge clk);
      a_valid = 2'b10; a_write = 2'b10;
      a_addr[63:32] = 32'h04; a_wdata[63:32] = 32'h12345678;
      #1;
      total++; if (a_ready !== 2'b10) begin bad++; $display("FAIL rm_accept: got %b want 10", a_ready); end
      @(negedge clk);
      a_valid = '0;
      reset = 1'b1;
      #1;
      total++; if (a_rvalid !== 2'b00) begin bad++; $display("FAIL rm_rvalid: got %b want 00", a_rvalid); end
      @(negedge clk);
      reset = 1'b0;
      a_xfer(1'b0, 1'b0, 32'h04, 32'h0, rd, er);
      total++; if (rd !== 32'h11111111) begin bad++; $display("FAIL rm_rdata: got %h want 11111111", rd); end
   endtask

   task automatic test_bounds();
      logic [31:0] rd;
      logic er;
      a_xfer(1'b0, 1'b1, 32'h04, 32'h5555AAAA, rd, er);
      a_xfer(1'b0, 1'b0, 32'h44, 32'h0, rd, er);
`ifdef MEM_ARBITER_BOUNDS_CHECK_EN
      total++; if (er !== 1'b1 || rd !== 32'h0) begin
         bad++; $display("FAIL oob_read: err %b rdata %h want 1/0", er, rd);
      end
`else
      total++; if (er !== 1'b0 || rd !== 32'h5555AAAA) begin
         bad++; $display("FAIL wrap_read: err %b rdata %h want 0/5555aaaa", er, rd);
      end
`endif
      a_xfer(1'b1, 1'b1, 32'h44, 32'h0BAD0BAD, rd, er);
      a_xfer(1'b0, 1'b0, 32'h04, 32'h0, rd, er);
`ifdef MEM_ARBITER_BOUNDS_CHECK_EN
      total++; if (rd !== 32'h5555AAAA) begin bad++; $display("FAIL oob_write_dropped: got %h", rd); end
`else
      total++; if (rd !== 32'h0BAD0BAD) begin bad++; $display("FAIL wrap_write: got %h", rd); end
`endif
   endtask

   task automatic test_withdraw();
      @(negedge clk);
      a_valid = 2'b01; a_write = 2'b01; a_addr[31:0] = 32'h00; a_wdata[31:0] = 32'h77;
      #1;
      total++; if (a_ready !== 2'b01) begin bad++; $display("FAIL wd_accept: got %b want 01", a_ready); end
      @(negedge clk);
      a_valid = 2'b10; a_write = 2'b00; a_addr[63:32] = 32'h08;
      #1;
      total++; if (a_ready !== 2'b00 || a_rvalid !== 2'b01) begin
         bad++; $display("FAIL wd_busy: ready %b rvalid %b want 00/01", a_ready, a_rvalid);
      end
      @(negedge clk);
      a_valid = '0;
      for (int k = 0; k < 3; k++) begin
         #1;
         total++; if (a_ready !== 2'b00 || a_rvalid !== 2'b00) begin
            bad++; $display("FAIL wd_idle[%0d]: ready %b rvalid %b want 00/00", k, a_ready, a_rvalid);
         end
         @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_round_robin();
      test_wait_states();
      test_reset_mid();
      test_bounds();
      test_withdraw();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Parametrised multi-requester memory subsystem: N independent requester channels share one internal word-organised, byte-addressed memory through a round-robin arbiter with a valid/ready request handshake and a configurable number of wait states. It replaces the fixed two-port, zero-latency memory hookup between the CPU and memory at system top level. Channel 0 is conventionally instruction fetch and channel 1 CPU data, with further channels free for DMA or debug masters.

## Interface
- NUM_PORTS, 2: requester channel count, 1..8
- NUM_BYTES, 64: storage size in bytes; multiple of 4
- WAIT_STATES, 0: extra cycles between accept and response, 0..15
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_PORTS  per-channel request present
- req_write  in  NUM_PORTS  1 = write, 0 = read
- req_addr  in  32*NUM_PORTS  byte address; channel i at [32*i+31:32*i]
- req_wdata  in  32*NUM_PORTS  write data, same packing
- req_ready  out  NUM_PORTS  request accepted this cycle (one-hot or zero)
- rsp_valid  out  NUM_PORTS  response pulse for owning channel (one-hot or zero)
- rsp_rdata  out  32*NUM_PORTS  read data, valid only with rsp_valid
- rsp_err  out  NUM_PORTS  error flag, valid only with rsp_valid

## Operation
- Word access only; word index = addr[31:2], addr[1:0] ignored; little-endian byte layout in storage.
- States: IDLE, WAIT, RESP.
- IDLE: if any req_valid, grant channel g = first set bit searching upward (modulo NUM_PORTS) from last_grant+1; req_ready[g]=1 combinationally that cycle; capture write, addr, wdata; last_grant<=g; go to WAIT if WAIT_STATES>0, else RESP. No req_valid: stay IDLE.
- WAIT: down-counter loaded with WAIT_STATES-1; on zero go to RESP. req_ready all 0.
- RESP: rsp_valid[g]=1 one cycle; read returns storage word; write commits storage at end of this cycle, rsp_rdata[g]=0; next state IDLE.
- Requester must hold req_valid/addr/wdata/write stable until req_ready; dropping req_valid before grant is allowed (no transaction).
- Read-after-write from any channel sees the committed value (commit precedes the next accept).
- Reset: state IDLE, last_grant = NUM_PORTS-1 (channel 0 wins first), counter 0, req_ready/rsp_valid/rsp_rdata/rsp_err all 0. Storage contents not cleared.
- Reset mid-transaction: transaction aborted, no response, write not committed even if reset coincides with the RESP edge.

## Timing
- Accept at cycle T (req_valid & req_ready high); rsp_valid at cycle T+1+WAIT_STATES.
- Next accept earliest T+2+WAIT_STATES; throughput one transaction per 2+WAIT_STATES cycles.
- rsp_* and req_ready never high in the same cycle.
- rsp_rdata/rsp_err of non-owning channels are 0.
- Only one outstanding transaction system-wide.

## Configuration
- MEM_ARBITER_BOUNDS_CHECK_EN defined: byte address >= NUM_BYTES yields rsp_err[g]=1 with the response; write dropped, rsp_rdata 0.
- Undefined: word index taken modulo NUM_BYTES/4 (wrap-around); rsp_err tied 0.

## Test plan
- Reset then single read, NUM_PORTS=2, WAIT_STATES=0: ch1 writes 0xDEADBEEF to 0x08 accepted at T, rsp_valid[1] at T+1; ch0 read 0x08 returns 0xDEADBEEF.
- All channels valid continuously, NUM_PORTS=4: grant order 0,1,2,3,0 with each channel's accept 2 cycles apart.
- WAIT_STATES=3: read accepted at T -> rsp_valid at T+4, req_ready low for T+1..T+4, next accept T+5.
- Reset asserted in the RESP cycle of a write 0x12345678 to 0x04 -> no rsp_valid, subsequent read of 0x04 returns prior value.
- Address 0x44 with NUM_BYTES=64: with MEM_ARBITER_BOUNDS_CHECK_EN read gives rsp_err=1, rdata 0; without it accesses word 0x04 (wraps), rsp_err=0.
- Request withdrawn: ch1 raises req_valid while ch0 owns bus, drops it before grant -> no ch1 transaction, no rsp_valid[1].
